// File: rtl/ps2_key_event_ctrl.sv
// PS/2 Set 2 scan-code sequencer: folds E0/F0 prefixes into key events and queues them in a FWFT FIFO.
// Define REPEAT_FILTER_EN to drop typematic repeats of the most recently pressed key.
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            emit;
    logic            emit_ext;
    logic            emit_brk;
    logic            accept;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        if (byte_valid) begin
            timer_d = '0;
            if (byte_in == 8'h00 || byte_in == 8'hFF) begin
                state_d = IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (byte_in == 8'hE0) begin
                            state_d = EXT;
                        end else if (byte_in == 8'hF0) begin
                            state_d = BRK;
                        end else if (byte_in != 8'hAA) begin
                            emit = 1'b1;
                        end
                    end
                    EXT: begin
                        if (byte_in == 8'hF0) begin
                            state_d = EXT_BRK;
                        end else if (byte_in != 8'hE0) begin
                            emit     = 1'b1;
                            emit_ext = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    BRK: begin
                        if (byte_in == 8'hE0) begin
                            state_d = EXT;
                        end else if (byte_in != 8'hF0) begin
                            emit     = 1'b1;
                            emit_brk = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    EXT_BRK: begin
                        if (byte_in != 8'hE0 && byte_in != 8'hF0) begin
                            emit     = 1'b1;
                            emit_ext = 1'b1;
                            emit_brk = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (state_q != IDLE) begin
            // Abandon a prefix whose follow-up byte never arrived.
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

`ifdef REPEAT_FILTER_EN
    logic       held_valid_q, held_valid_d;
    logic       held_ext_q, held_ext_d;
    logic [7:0] held_code_q, held_code_d;
    logic       held_match;

    always_comb begin
        held_valid_d = held_valid_q;
        held_ext_d   = held_ext_q;
        held_code_d  = held_code_q;
        accept       = emit;
        held_match   = held_valid_q && (held_ext_q == emit_ext) && (held_code_q == byte_in);
        if (emit) begin
            if (!emit_brk) begin
                if (held_match) begin
                    accept = 1'b0;
                end else begin
                    held_valid_d = 1'b1;
                    held_ext_d   = emit_ext;
                    held_code_d  = byte_in;
                end
            end else if (held_match) begin
                held_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid_q <= 1'b0;
            held_ext_q   <= 1'b0;
            held_code_q  <= 8'h00;
        end else begin
            held_valid_q <= held_valid_d;
            held_ext_q   <= held_ext_d;
            held_code_q  <= held_code_d;
        end
    end
`else
    assign accept = emit;
`endif

    // Decoded event is staged one cycle before it reaches the FIFO.
    logic       pend_valid_q;
    logic       pend_ext_q;
    logic       pend_brk_q;
    logic [7:0] pend_code_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_ext_q   <= 1'b0;
            pend_brk_q   <= 1'b0;
            pend_code_q  <= 8'h00;
        end else begin
            pend_valid_q <= accept;
            if (accept) begin
                pend_ext_q  <= emit_ext;
                pend_brk_q  <= emit_brk;
                pend_code_q <= byte_in;
            end
        end
    end

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] count_q;
    logic          overflow_q;
    logic          full;
    logic          pop;
    logic          do_push;
    logic [9:0]    head;

    assign full    = (count_q == LW'(FIFO_DEPTH));
    assign pop     = evt_valid && evt_ready;
    assign do_push = pend_valid_q && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !pop) begin
                count_q <= count_q + LW'(1);
            end else if (pop && !do_push) begin
                count_q <= count_q - LW'(1);
            end
            if (pend_valid_q && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {pend_ext_q, pend_brk_q, pend_code_q};
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign evt_valid  = (count_q != '0);
    assign evt_code   = evt_valid ? head[7:0] : 8'h00;
    assign evt_break  = evt_valid ? head[8] : 1'b0;
    assign evt_ext    = evt_valid ? head[9] : 1'b0;
    assign overflow   = overflow_q;
    assign fifo_level = count_q;

endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

Sequencing controller between the PS/2 byte receiver and the game/display logic. It turns the raw scan-code byte stream (Set 2) into complete key events by tracking the 0xE0 (extended) and 0xF0 (break) prefixes. Finished events are buffered in a small FIFO and delivered through a valid/ready handshake. A watchdog drops prefix sequences left incomplete, and an optional filter suppresses typematic repeats.

## Interface
Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 200000: clk cycles a partial prefix sequence may wait for its next byte (2 ms at 100 MHz).

Ports:
- clk  in  1  onboard clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- byte_in  in  8  scan-code byte from the receiver; sampled only when byte_valid=1.
- byte_valid  in  1  one-cycle strobe per received byte; may assert on consecutive cycles.
- evt_code  out  8  final scan code of the head event; 0 when the FIFO is empty.
- evt_ext  out  1  head event was 0xE0-prefixed; 0 when empty.
- evt_break  out  1  head event is a release (0xF0-prefixed); 0 when empty.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer accepts the head event in a cycle where evt_valid=1.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full; cleared only by rst.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.

## Operation
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK. It advances only on byte_valid.
- Bytes 0x00 or 0xFF (keyboard error/overrun) in any state: go to IDLE, no event.
- IDLE:
  - 0xE0 → EXT; 0xF0 → BRK.
  - 0xAA (BAT pass) is dropped; stay IDLE.
  - Any other byte: emit {ext=0, brk=0, code}.
- EXT:
  - 0xF0 → EXT_BRK; 0xE0 → stay in EXT.
  - Any other byte: emit {1,0,code} → IDLE.
- BRK:
  - 0xE0 → EXT; 0xF0 → stay in BRK.
  - Any other byte: emit {0,1,code} → IDLE.
- EXT_BRK:
  - 0xE0 or 0xF0 → stay in EXT_BRK.
  - Any other byte: emit {1,1,code} → IDLE.
- Watchdog: a counter clears on every byte_valid and counts while the state is not IDLE. When it reaches TIMEOUT_CYCLES−1 the state goes to IDLE and nothing is emitted. In IDLE the counter is held at 0.
- FIFO is first-word-fall-through:
  - Push on emit; pop when evt_valid & evt_ready.
  - Full with push and no pop: the event is dropped and overflow is set.
  - Full with push and pop in the same cycle: both take effect, level stays FIFO_DEPTH, no overflow.
  - Empty with push: the pop is not possible in that cycle, since evt_valid=0.
- Pointers wrap modulo FIFO_DEPTH; fifo_level is updated in the same cycle as the push/pop.

## Timing
- Reset values:
  - state IDLE, timer 0, FIFO empty.
  - evt_valid=0, evt_code=0, evt_ext=0, evt_break=0.
  - overflow=0, fifo_level=0, repeat-filter register invalid.
- Latency: when the final byte of a sequence arrives at edge N into an empty FIFO, evt_valid and the event fields are valid after edge N+1 (one registered stage).
- Handshake:
  - Event fields are stable while evt_valid=1 and evt_ready=0.
  - After a pop, the next entry (if any) appears at the following edge.
- Back-to-back byte_valid is fully supported; each strobe advances the FSM exactly once.
- rst asserted mid-sequence discards any partial prefix and all buffered events at that edge. A byte_valid coincident with rst is ignored.

## Configuration
- REPEAT_FILTER_EN defined:
  - A register holds {ext, code, valid} of the last accepted make.
  - A make equal to the held key while valid=1 is not pushed (typematic repeat).
  - A break of the held key clears valid and is pushed.
  - A make of a different key replaces the register and is pushed.
  - Filtered events never set overflow.
- REPEAT_FILTER_EN undefined: every decoded event is pushed; no filter register is built.

## Test plan
- Single make: byte 0x1C at edge N → evt_valid=1 after N+1 with code 0x1C, ext=0, break=0; pop with evt_ready=1 → evt_valid=0, fifo_level=0.
- Extended break: 0xE0, 0xF0, 0x75 → one event {code 0x75, ext=1, break=1}; 0xE0 alone produces no event.
- Timeout: 0xF0, then idle for TIMEOUT_CYCLES cycles, then 0x1C → single event {0x1C, ext=0, break=0}. Also check that 0xF0 followed by 0x1C after TIMEOUT_CYCLES−2 idle cycles yields a break.
- Overflow: evt_ready=0, send 5 make codes 0x15, 0x1D, 0x24, 0x2D, 0x2C with FIFO_DEPTH=4 → fifo_level=4, overflow=1. Draining returns 0x15, 0x1D, 0x24, 0x2D in order, and overflow stays 1. Also check a push+pop when full leaves level 4 with overflow unchanged.
- Repeat filter: stream 0x1C, 0x1C, 0x1C, 0xF0 0x1C, 0x1C.
  - With REPEAT_FILTER_EN: make 1C, break 1C, make 1C.
  - Without REPEAT_FILTER_EN: three makes, break, make.
- Reset mid-sequence: 0xE0, assert rst for one cycle, then 0x75 → event {0x75, ext=0, break=0}; all outputs read their reset values during rst.
